// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the in-order pipeline, with a stall-episode watchdog.
// Define HAZARD_STATS_EN to add the stall_cycles / fwd_events counter outputs.
module hazard_fwd_unit #(
  parameter int REG_AW         = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_FWD_STAGE = 1,
  parameter int MAX_STALL      = 4,
  localparam int SELW          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [REG_AW-1:0]                ra,
  input  logic [REG_AW-1:0]                rb,
  input  logic                             use_a,
  input  logic                             use_b,
  input  logic                             flush,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] dst_rw,
  input  logic [NUM_FWD_STAGES-1:0]        dst_wr,
  input  logic [NUM_FWD_STAGES-1:0]        dst_load,
  output logic [SELW-1:0]                  fwd_a,
  output logic [SELW-1:0]                  fwd_b,
  output logic                             stall,
  output logic                             bubble,
  output logic                             stall_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                      stall_cycles,
  output logic [31:0]                      fwd_events
`endif
);

  localparam int CW = $clog2(MAX_STALL + 1);

  typedef enum logic {RUN, STALL} state_e;

  // Returns {hazard, select} for one operand; the nearest matching stage decides.
  function automatic logic [SELW:0] resolve(input logic             use_r,
                                            input logic [REG_AW-1:0] r);
    logic [SELW-1:0] sel;
    logic            haz;
    sel = '0;
    haz = 1'b0;
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (use_r && dst_wr[k] && (dst_rw[k*REG_AW +: REG_AW] == r) && (r != '0)) begin
        haz = dst_load[k] && (k < LOAD_FWD_STAGE);
        sel = haz ? '0 : SELW'(k + 1);
      end
    end
    return {haz, sel};
  endfunction

  logic [SELW:0]   res_a, res_b;
  logic            hazard;
  logic            squash;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    res_a  = resolve(use_a, ra);
    res_b  = resolve(use_b, rb);
    hazard = res_a[SELW] | res_b[SELW];
    squash = flush | reset;
    stall  = hazard & ~squash;
    bubble = stall;
    fwd_a  = squash ? '0 : res_a[SELW-1:0];
    fwd_b  = squash ? '0 : res_b[SELW-1:0];
  end

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;

  // NOTE: state uses non-blocking assignments and a synchronous reset sampled on the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (stall) begin
            state_q <= STALL;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        STALL: begin
          if (!stall) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else if (cnt_q < CW'(MAX_STALL)) begin
            cnt_q   <= cnt_q + CW'(1);
          end else begin
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stall_err = err_q & ~reset;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_events_q,   fwd_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + (stall ? 32'd1 : 32'd0);
    fwd_events_d   = fwd_events_q +
                     ((!stall && ((fwd_a != '0) || (fwd_b != '0))) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = reset ? 32'd0 : stall_cycles_q;
  assign fwd_events   = reset ? 32'd0 : fwd_events_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed cases plus randomized traffic against a behavioural model.
module tb_hazard_fwd_unit;

  localparam int REG_AW = 5;
  localparam int NS     = 2;
  localparam int LFS    = 1;
  localparam int MAXS   = 4;
  localparam int SELW   = $clog2(NS + 1);

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [REG_AW-1:0]       ra = '0, rb = '0;
  logic                    use_a = 1'b0, use_b = 1'b0, flush = 1'b0;
  logic [NS*REG_AW-1:0]    dst_rw = '0;
  logic [NS-1:0]           dst_wr = '0, dst_load = '0;
  logic [SELW-1:0]         fwd_a, fwd_b;
  logic                    stall, bubble, stall_err;
`ifdef HAZARD_STATS_EN
  logic [31:0]             stall_cycles, fwd_events;
`endif

  hazard_fwd_unit #(
    .REG_AW(REG_AW), .NUM_FWD_STAGES(NS), .LOAD_FWD_STAGE(LFS), .MAX_STALL(MAXS)
  ) dut (
    .clock(clock), .reset(reset), .ra(ra), .rb(rb), .use_a(use_a), .use_b(use_b),
    .flush(flush), .dst_rw(dst_rw), .dst_wr(dst_wr), .dst_load(dst_load),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble(bubble), .stall_err(stall_err)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .fwd_events(fwd_events)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] fa;
    logic [31:0] fb;
    logic        stall;
  } exp_t;

  // Spec rules: first (nearest) matching stage decides; a near load is a hazard.
  function automatic exp_t model_comb();
    exp_t              e;
    int                sel [2];
    bit                haz [2];
    logic [REG_AW-1:0] r   [2];
    bit                u   [2];
    r[0] = ra; r[1] = rb; u[0] = use_a; u[1] = use_b;
    for (int op = 0; op < 2; op++) begin
      sel[op] = 0;
      haz[op] = 0;
      for (int k = 0; k < NS; k++) begin
        if (u[op] && dst_wr[k] && dst_rw[k*REG_AW +: REG_AW] == r[op] && r[op] != 0) begin
          if (dst_load[k] && k < LFS) haz[op] = 1;
          else sel[op] = k + 1;
          break;
        end
      end
    end
    e.stall = (haz[0] || haz[1]) && !flush && !reset;
    e.fa    = (flush || reset) ? 0 : sel[0];
    e.fb    = (flush || reset) ? 0 : sel[1];
    return e;
  endfunction

  int          m_run = 0;
  bit          m_err = 0;
  logic [31:0] m_sc = '0, m_fe = '0;
  bit          model_on = 0;

  always @(posedge clock) begin
    exp_t e;
    e = model_comb();
    if (reset) begin
      m_run = 0; m_err = 0; m_sc = '0; m_fe = '0;
      model_on = 1;
    end else begin
      if (e.stall) begin
        m_run++;
        if (m_run >= MAXS + 1) m_err = 1;
      end else begin
        m_run = 0;
      end
      if (e.stall) m_sc = m_sc + 1;
      if (!e.stall && (e.fa != 0 || e.fb != 0)) m_fe = m_fe + 1;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (model_on) begin
      e = model_comb();
      check("cmp_fwd_a",  32'(fwd_a),  e.fa);
      check("cmp_fwd_b",  32'(fwd_b),  e.fb);
      check("cmp_stall",  32'(stall),  32'(e.stall));
      check("cmp_bubble", 32'(bubble), 32'(e.stall));
      check("cmp_err",    32'(stall_err), reset ? 32'd0 : 32'(m_err));
`ifdef HAZARD_STATS_EN
      check("cmp_stall_cycles", stall_cycles, reset ? 32'd0 : m_sc);
      check("cmp_fwd_events",   fwd_events,   reset ? 32'd0 : m_fe);
`endif
    end
  end

  task automatic drive(input logic [4:0] a, input bit ua, input logic [4:0] b, input bit ub,
                       input bit fl, input bit rs, input logic [4:0] d0, input logic [4:0] d1,
                       input logic [1:0] wr, input logic [1:0] ld);
    @(posedge clock);
    #1;
    ra = a; use_a = ua; rb = b; use_b = ub; flush = fl; reset = rs;
    dst_rw = {d1, d0}; dst_wr = wr; dst_load = ld;
  endtask

  task automatic look();
    @(negedge clock);
    #1;
  endtask

  initial begin
    // Reset masks everything, even a live load-use hazard.
    drive(3, 1, 0, 0, 0, 1, 3, 0, 2'b01, 2'b01); look();
    check("rst_fwd_a", 32'(fwd_a), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_err",   32'(stall_err), 0);

    drive(3, 1, 0, 0, 0, 0, 3, 0, 2'b01, 2'b00); look();
    check("t1_fwd_a", 32'(fwd_a), 1);
    check("t1_stall", 32'(stall), 0);

    drive(5, 1, 0, 0, 0, 0, 5, 5, 2'b11, 2'b00); look();
    check("t2_nearest", 32'(fwd_a), 1);
    drive(5, 1, 0, 0, 0, 0, 5, 5, 2'b10, 2'b00); look();
    check("t2_far", 32'(fwd_a), 2);

    drive(0, 0, 7, 1, 0, 0, 7, 0, 2'b01, 2'b01); look();
    check("t3_stall",  32'(stall),  1);
    check("t3_bubble", 32'(bubble), 1);
    check("t3_fwd_b",  32'(fwd_b),  0);
    drive(0, 0, 7, 1, 0, 0, 0, 7, 2'b10, 2'b10); look();
    check("t3_fwd_b_adv", 32'(fwd_b), 2);
    check("t3_stall_adv", 32'(stall), 0);

    drive(0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b01); look();
    check("t4_r0_fwd",   32'(fwd_a), 0);
    check("t4_r0_stall", 32'(stall), 0);

    drive(3, 1, 7, 1, 1, 0, 7, 3, 2'b11, 2'b01); look();
    check("t5_flush_stall", 32'(stall), 0);
    check("t5_flush_fwd_a", 32'(fwd_a), 0);
    check("t5_flush_fwd_b", 32'(fwd_b), 0);

    drive(0, 0, 7, 1, 0, 0, 7, 0, 2'b01, 2'b01); look();
    check("t5_pre_rst_stall", 32'(stall), 1);
    drive(0, 0, 7, 1, 0, 1, 7, 0, 2'b01, 2'b01); look();
    check("t5_rst_stall",  32'(stall),  0);
    check("t5_rst_bubble", 32'(bubble), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00); look();
    check("t5_post_rst_err", 32'(stall_err), 0);

    for (int i = 0; i < MAXS + 1; i++) begin
      drive(9, 1, 0, 0, 0, 0, 9, 0, 2'b01, 2'b01); look();
      check("t6_stall_held", 32'(stall), 1);
      check("t6_err_early",  32'(stall_err), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00); look();
    check("t6_err_set", 32'(stall_err), 1);
`ifdef HAZARD_STATS_EN
    check("t6_stall_cycles", stall_cycles, MAXS + 1);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00); look();
    check("t6_err_sticky", 32'(stall_err), 1);

    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00); look();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
